// File: rtl/param_shift_add_mult_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_e      : controller states (IDLE, CALC, FINISH)
//   calc_latency : number of busy cycles for one multiplication (WIDTH+1)
package param_shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // One cycle per shift-add iteration plus the final write cycle.
  function automatic int unsigned calc_latency(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/param_mult_datapath.sv
// Datapath of the shift-add multiplier: operand magnitudes, result sign,
// accumulator, iteration counter, adder and final negator.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load_i         : latch operands, clear accumulator and counter
//   add_shift_i    : perform one shift-add iteration
//   final_wr_i     : write (optionally negated) accumulator into product
//   sgn_i, a_i, b_i: operand mode and operands (used only with load_i)
//   last_o         : high while the counter is on the final iteration
//   product_o      : registered product
module param_mult_datapath
  import param_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 add_shift_i,
  input  logic                 final_wr_i,
  input  logic                 sgn_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   product_o
);

  // Counter must be able to hold values up to WIDTH.
  localparam int CW = $clog2(calc_latency(WIDTH));

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum_w;

  // Magnitudes fit in WIDTH unsigned bits: -2^(WIDTH-1) negates to the same
  // bit pattern, which read unsigned is exactly 2^(WIDTH-1).
  assign a_mag = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Upper half plus multiplicand, keeping the carry as bit WIDTH.
  assign sum_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  assign last_o    = (cnt_q == CW'(WIDTH - 1));
  assign product_o = product_q;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    if (load_i) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      // A zero operand always gives a positive result.
      sign_d   = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (|a_i) & (|b_i);
      acc_d    = '0;
      cnt_d    = '0;
    end else if (add_shift_i) begin
      // Carry lands in the top bit after the right shift.
      acc_d    = {sum_w, acc_q[WIDTH-1:1]};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end

    if (final_wr_i) begin
      product_d = sign_q ? -acc_q : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: rtl/param_shift_add_mult.sv
// Sequential shift-add multiplier (unsigned or two's-complement signed).
// The controller lives here; arithmetic state is in param_mult_datapath.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request a multiplication
//   sgn       : 0 = unsigned, 1 = signed operands
//   a, b      : multiplicand, multiplier (WIDTH bits)
//   product   : registered 2*WIDTH-bit result, held between completions
//   busy      : high while an operation is in progress (WIDTH+1 cycles)
//   done      : one-cycle pulse in the cycle product is updated
//   state_dbg : current controller state (state_e encoding)
//
// Handshake: start is a level request with no ready; it is only sampled
// while the controller is IDLE and ignored otherwise. The request is taken
// on the edge where state is IDLE and start=1; a, b and sgn matter only on
// that edge. Holding start high restarts on the first IDLE cycle, which is
// the cycle done is high.
module param_shift_add_mult
  import param_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic   load;
  logic   add_shift;
  logic   final_wr;
  logic   last;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    add_shift = 1'b0;
    final_wr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        add_shift = 1'b1;
        if (last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        final_wr = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  param_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .add_shift_i(add_shift),
    .final_wr_i (final_wr),
    .sgn_i      (sgn),
    .a_i        (a),
    .b_i        (b),
    .last_o     (last),
    .product_o  (product)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_param_shift_add_mult.sv
// Bench for param_shift_add_mult with one WIDTH=4 and one WIDTH=8 instance.
module tb_param_shift_add_mult;
  import param_shift_add_mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  product4;
  logic        busy4, done4;
  logic [1:0]  state4;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;
  logic        busy8, done8;
  logic [1:0]  state8;

  param_shift_add_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
    .product(product4), .busy(busy4), .done(done4), .state_dbg(state4)
  );

  param_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .product(product8), .busy(busy8), .done(done8), .state_dbg(state8)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];
  logic [7:0]  e4;
  logic [15:0] e8;
  logic        prev_done4 = 1'b0, prev_done8 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      check("done8_single_pulse", {31'd0, prev_done8}, 32'd0);
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected_done: done with product 0x%0h, required no done (t=%0t)", product8, $time);
      end else begin
        e8 = exp8_q.pop_front();
        check("sb8_product", {16'd0, product8}, {16'd0, e8});
      end
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      check("done4_single_pulse", {31'd0, prev_done4}, 32'd0);
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected_done: done with product 0x%0h, required no done (t=%0t)", product4, $time);
      end else begin
        e4 = exp4_q.pop_front();
        check("sb4_product", {24'd0, product4}, {24'd0, e4});
      end
    end
    prev_done4 = done4;
  end

  // Reference product, truncated to 2*w bits.
  function automatic logic [15:0] model(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
    longint av, bv, p, m;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (s && av[w-1]) av = av - (longint'(1) << w);
    if (s && bv[w-1]) bv = bv - (longint'(1) << w);
    p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
    return p[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int w, input logic [7:0] ai, input logic [7:0] bi,
                       input logic s, input logic [15:0] e);
    @(negedge clk);
    if (w == 4) begin
      a4 = ai[3:0]; b4 = bi[3:0]; sgn4 = s; start4 = 1'b1;
      exp4_q.push_back(e[7:0]);
    end else begin
      a8 = ai; b8 = bi; sgn8 = s; start8 = 1'b1;
      exp8_q.push_back(e);
    end
    @(negedge clk);
    // Operands are don't-care after the sampling edge: scramble them.
    start4 = 1'b0; start8 = 1'b0;
    a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    sgn4 = 1'($urandom_range(0, 1)); sgn8 = 1'($urandom_range(0, 1));
  endtask

  // n counts negedges after the sampling edge until done; busy_n counts busy samples.
  task automatic wait_done(input int w, output int n, output int busy_n);
    logic d, bz;
    n = 0;
    busy_n = 0;
    d = 1'b0;
    while (n <= 40) begin
      d  = (w == 4) ? done4 : done8;
      bz = (w == 4) ? busy4 : busy8;
      if (bz) busy_n++;
      if (d) break;
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen_w%0d", w), {31'd0, d}, 32'd1);
  endtask

  task automatic run_vec(input int w, input logic [7:0] ai, input logic [7:0] bi,
                         input logic s, input logic [15:0] e);
    int n, bn;
    issue(w, ai, bi, s, e);
    wait_done(w, n, bn);
    check($sformatf("latency_w%0d", w), n, w + 1);
    check($sformatf("busy_cycles_w%0d", w), bn, w + 1);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] e;
  } vec_t;

  vec_t tab4[5];
  vec_t tab8[8];
  int   t_done[4];

  initial begin
    int n, bn;
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] last8;

    tab4[0] = '{8'h0F, 8'h0F, 1'b0, 16'h00E1};
    tab4[1] = '{8'h08, 8'h08, 1'b1, 16'h0040};
    tab4[2] = '{8'h08, 8'h00, 1'b1, 16'h0000};
    tab4[3] = '{8'h08, 8'h07, 1'b1, 16'h00C8};
    tab4[4] = '{8'h0F, 8'h0F, 1'b1, 16'h0001};

    tab8[0] = '{8'hF8, 8'h07, 1'b1, 16'hFFC8};
    tab8[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tab8[2] = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    tab8[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tab8[4] = '{8'h00, 8'h85, 1'b1, 16'h0000};
    tab8[5] = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
    tab8[6] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tab8[7] = '{8'h03, 8'h05, 1'b0, 16'h000F};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_product8", {16'd0, product8}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_state8", {30'd0, state8}, {30'd0, IDLE});
    check("rst_product4", {24'd0, product4}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    rst = 1'b0;

    // Table-driven vectors
    foreach (tab4[i]) run_vec(4, tab4[i].a, tab4[i].b, tab4[i].s, tab4[i].e);
    foreach (tab8[i]) run_vec(8, tab8[i].a, tab8[i].b, tab8[i].s, tab8[i].e);

    // Random vectors against the reference model
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_vec(8, ra, rb, rs, model(8, ra, rb, rs));
    end
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      run_vec(4, ra, rb, rs, model(4, ra, rb, rs));
    end

    // Product holds while operands wiggle
    run_vec(8, 8'd200, 8'd3, 1'b0, 16'd600);
    last8 = 16'd600;
    repeat (6) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    end
    check("hold_product8", {16'd0, product8}, {16'd0, last8});

    // start pulsed mid-CALC is ignored
    issue(8, 8'd3, 8'd5, 1'b0, 16'd15);
    repeat (3) @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(8, n, bn);
    repeat (15) @(negedge clk);
    check("ignore_busy8", {31'd0, busy8}, 32'd0);
    check("ignore_product8", {16'd0, product8}, 32'd15);

    // Reset at CALC iteration 4
    issue(8, 8'd12, 8'd12, 1'b0, 16'd144);
    repeat (3) @(negedge clk);
    check("pre_rst_state_calc", {30'd0, state8}, {30'd0, CALC});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp8_q.delete();
    check("calc_rst_product8", {16'd0, product8}, 32'd0);
    check("calc_rst_state8", {30'd0, state8}, {30'd0, IDLE});
    repeat (15) @(negedge clk);
    check("calc_rst_busy8", {31'd0, busy8}, 32'd0);
    check("calc_rst_product8_late", {16'd0, product8}, 32'd0);
    run_vec(8, 8'd2, 8'd3, 1'b0, 16'd6);

    // Reset in FINISH
    issue(8, 8'h11, 8'h11, 1'b0, 16'h0121);
    repeat (8) @(negedge clk);
    check("pre_rst_state_finish", {30'd0, state8}, {30'd0, FINISH});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp8_q.delete();
    check("fin_rst_product8", {16'd0, product8}, 32'd0);
    check("fin_rst_done8", {31'd0, done8}, 32'd0);
    check("fin_rst_busy8", {31'd0, busy8}, 32'd0);
    repeat (12) @(negedge clk);

    // start held high: one result every WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd2; sgn8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back(16'd4);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done8 && n < 40);
      check("held_done_seen", {31'd0, done8}, 32'd1);
      t_done[i] = cyc;
      if (i == 3) start8 = 1'b0;
      else exp8_q.push_back(16'd4);
    end
    for (int i = 1; i < 4; i++) check("held_period", t_done[i] - t_done[i-1], 10);
    repeat (15) @(negedge clk);
    check("held_end_busy8", {31'd0, busy8}, 32'd0);

    // Nothing left outstanding
    check("sb8_empty", exp8_q.size(), 0);
    check("sb4_empty", exp4_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_shift_add_mult.md
PARAM_SHIFT_ADD_MULT -- requirements
Module: param_shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiplication.
REQ-005 The block SHALL have port sgn, input, 1, mode select: 0 = unsigned, 1 = two's-complement signed.
REQ-006 The block SHALL have port a, input, WIDTH, multiplicand.
REQ-007 The block SHALL have port b, input, WIDTH, multiplier.
REQ-008 The block SHALL have port product, output, 2*WIDTH, registered result.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1, single-cycle pulse marking product update.

Function
REQ-011 The controller SHALL implement states IDLE, CALC and FINISH.
REQ-012 In IDLE with start=1, the block SHALL, on that edge, latch a, b and sgn, clear the accumulator and iteration counter, set busy=1 and enter CALC.
REQ-013 Operand latching in signed mode SHALL store magnitudes |a| and |b| as WIDTH-bit unsigned values, plus result sign = a[MSB] XOR b[MSB]; unsigned mode SHALL use raw values with result sign 0.
REQ-014 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), represented without overflow.
REQ-015 CALC SHALL perform exactly WIDTH shift-add iterations, one per cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator with carry retained, then shift the accumulator and multiplier right by 1.
REQ-016 After the WIDTH-th iteration, the controller SHALL enter FINISH.
REQ-017 On the FINISH edge, the block SHALL load product with the accumulator, two's-complement negated if the result sign is 1.
REQ-018 On the same FINISH edge, the block SHALL set done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-019 Latency: done SHALL be high in the cycle following edge WIDTH+1, counting the start-sampling edge as edge 0; busy SHALL be high for exactly WIDTH+1 cycles.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-021 start held high continuously SHALL begin a new operation in the cycle after done, i.e. on the first IDLE cycle, with back-to-back throughput of one result per WIDTH+2 cycles.
REQ-022 a, b and sgn SHALL be don't-care except on the start-sampling edge.
REQ-023 product SHALL hold its value between completions and SHALL be unaffected by operand changes.
REQ-024 A zero operand SHALL yield product 0 with sign forced positive, never negative zero artefacts.

Reset
REQ-025 rst=1 SHALL override all other inputs on that edge.
REQ-026 On reset, state SHALL be IDLE, and product=0, busy=0, done=0, accumulator=0 and counter=0.
REQ-027 Reset asserted mid-CALC or in FINISH SHALL abort the operation with no done pulse, leaving product=0.
REQ-028 The first start accepted after reset deasserts SHALL behave per REQ-012.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, CALC, FINISH) and the latency constant function (WIDTH+1).
REQ-030 The block SHALL be split into a controller and one sub-module, param_mult_datapath, holding the operand, accumulator and counter registers and the adder/negator.
REQ-031 The controller-to-datapath control signals SHALL be load, add-shift and final-write strobes only.

Verification
REQ-032 With WIDTH=4, sgn=0, a=15, b=15 and start for one cycle, product SHALL be 0xE1 (225), with done pulsed once 5 cycles after start is sampled.
REQ-033 With WIDTH=8, sgn=1, a=0xF8 (-8), b=0x07, product SHALL be 0xFFC8 (-56), with busy high 9 cycles.
REQ-034 With WIDTH=4, sgn=1, a=0x8, b=0x8 (-8*-8), product SHALL be 0x40 (64), and with a=0x8, b=0x0, product SHALL be 0x00.
REQ-035 With WIDTH=8, starting 3*5, then pulsing start with a=9, b=9 mid-CALC: one done pulse SHALL occur with product 15, and the second request SHALL be ignored.
REQ-036 With WIDTH=8, starting 12*12 then asserting rst for one cycle at CALC iteration 4: product SHALL be 0, busy and done SHALL stay 0, and a following 2*3 SHALL yield 6.
REQ-037 With WIDTH=8 and start held high, a=b=2: done SHALL pulse every 10 cycles with product 4.
